// File: rtl/lpddr4_refresher_if.sv
// Command-port bundle between the refresher and the 8-bank command multiplexer.
// The refresher is the master; the multiplexer answers with cmd_ready.
interface lpddr4_refresher_if #(
  parameter int ADDR_W = 17,
  parameter int BA_W   = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_first;
  logic              cmd_last;
  logic [ADDR_W-1:0] cmd_payload_a;
  logic [BA_W-1:0]   cmd_payload_ba;
  logic              cmd_payload_cas;
  logic              cmd_payload_ras;
  logic              cmd_payload_we;

  modport master (
    output cmd_valid, cmd_first, cmd_last,
    output cmd_payload_a, cmd_payload_ba,
    output cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_first, cmd_last,
    input  cmd_payload_a, cmd_payload_ba,
    input  cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
    output cmd_ready
  );
endinterface

// File: rtl/lpddr4_refresher.sv
// Periodic LPDDR4 refresh generator: counts tREFI intervals, tracks owed refreshes,
// and runs PRECHARGE-ALL / tRP / REFRESH / tRFC sequences on the multiplexer port.
module lpddr4_refresher #(
  parameter int ADDR_W   = 17,
  parameter int BA_W     = 3,
  parameter int MAX_PEND = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 refresh_en,
  input  logic [15:0]          tREFI_cfg,
  input  logic [7:0]           tRP_cfg,
  input  logic [9:0]           tRFC_cfg,
  lpddr4_refresher_if.master   cmd,
  output logic [3:0]           pending,
  output logic                 refresh_busy
);

  typedef enum logic [2:0] {
    IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC, DONE
  } state_t;

  localparam logic [3:0] PEND_MAX = 4'(MAX_PEND);

  state_t            state_q, state_d;
  logic [9:0]        wait_q, wait_d;
  logic [15:0]       refi_cnt;
  logic              tick;
  logic              done;
  logic [ADDR_W-1:0] a_c;

  assign tick = refresh_en && (refi_cnt == '0);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      refi_cnt <= tREFI_cfg - 16'd1;
    end else if (refresh_en) begin
      if (tick) refi_cnt <= tREFI_cfg - 16'd1;
      else      refi_cnt <= refi_cnt - 16'd1;
    end
  end

  // A tick coinciding with DONE cancels out; a tick at saturation is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (tick && !done && (pending != PEND_MAX)) begin
      pending <= pending + 4'd1;
    end else if (done && !tick) begin
      pending <= pending - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    wait_d              = wait_q;
    a_c                 = '0;
    cmd.cmd_valid       = 1'b0;
    cmd.cmd_first       = 1'b0;
    cmd.cmd_last        = 1'b0;
    cmd.cmd_payload_cas = 1'b0;
    cmd.cmd_payload_ras = 1'b0;
    cmd.cmd_payload_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending != '0) state_d = REQ;
      end
      REQ: begin
        cmd.cmd_valid = 1'b1;
        if (cmd.cmd_ready) state_d = PRE;
      end
      PRE: begin
        cmd.cmd_valid       = 1'b1;
        cmd.cmd_first       = 1'b1;
        cmd.cmd_payload_ras = 1'b1;
        cmd.cmd_payload_we  = 1'b1;
        a_c[10]             = 1'b1;
        wait_d              = {2'b00, tRP_cfg} - 10'd1;
        state_d             = WAIT_RP;
      end
      WAIT_RP: begin
        cmd.cmd_valid = 1'b1;
        if (wait_q == '0) state_d = REF;
        else              wait_d  = wait_q - 10'd1;
      end
      REF: begin
        cmd.cmd_valid       = 1'b1;
        cmd.cmd_payload_ras = 1'b1;
        cmd.cmd_payload_cas = 1'b1;
        wait_d              = tRFC_cfg - 10'd1;
        state_d             = WAIT_RFC;
      end
      WAIT_RFC: begin
        cmd.cmd_valid = 1'b1;
        if (wait_q == '0) state_d = DONE;
        else              wait_d  = wait_q - 10'd1;
      end
      DONE: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_last  = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd.cmd_payload_a  = a_c;
  assign cmd.cmd_payload_ba = {BA_W{1'b0}};
  assign refresh_busy       = (state_q != IDLE);

endmodule

// File: doc/lpddr4_refresher.md
# lpddr4_refresher

Periodic refresh generator that sits directly upstream of the 8-bank command multiplexer and drives its dedicated refresher command port.
- Counts tREFI intervals and keeps a saturating count of owed refreshes (up to 8 postponed).
- For each owed refresh, requests the command bus and waits for the multiplexer to grant it, which happens only after all bank machines have acknowledged their refresh request.
- Issues PRECHARGE-ALL, waits tRP, issues REFRESH, waits tRFC, then releases the bus with cmd_last.

## Interface
Parameters:
- ADDR_W, 17, width of cmd_payload_a
- BA_W, 3, width of cmd_payload_ba
- MAX_PEND, 8, saturation limit of the owed-refresh counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- refresh_en  in  1  enables tREFI counting; 0 freezes the timer
- tREFI_cfg  in  16  refresh interval in cycles, valid range ≥ 2
- tRP_cfg  in  8  cycles from PRECHARGE-ALL to REFRESH, valid range ≥ 1
- tRFC_cfg  in  10  cycles from REFRESH to release, valid range ≥ 1
- cmd_valid  out  1  refresher owns or requests the command bus
- cmd_ready  in  1  multiplexer grant / command accepted
- cmd_first  out  1  first cycle of a granted sequence
- cmd_last  out  1  final cycle of the sequence; multiplexer releases bus
- cmd_payload_a  out  ADDR_W  address; bit 10 set during PRECHARGE-ALL
- cmd_payload_ba  out  BA_W  always 0
- cmd_payload_cas  out  1  CAS strobe
- cmd_payload_ras  out  1  RAS strobe
- cmd_payload_we  out  1  WE strobe
- pending  out  4  owed-refresh count, 0..MAX_PEND
- refresh_busy  out  1  FSM not in IDLE

## Operation
Interval timer:
- 16-bit down-counter, reloaded with tREFI_cfg-1 on reset.
- Decrements while refresh_en=1.
- At 0 it produces a one-cycle tick and reloads with tREFI_cfg-1.
- refresh_en=0 holds the counter value.

Pending counter:
- Increments on a tick and decrements on DONE; a simultaneous tick and DONE leave it unchanged.
- Saturates at MAX_PEND; a tick at saturation is dropped.
- Never underflows, because DONE is reachable only with pending ≥ 1.

FSM states:
- IDLE: cmd_valid=0. If pending ≠ 0, go to REQ.
- REQ: cmd_valid=1, all strobes 0. On cmd_ready=1, go to PRE.
- PRE: one cycle.
  - cmd_valid=1, cmd_first=1, ras=1, we=1, cas=0, a[10]=1.
  - Load the wait counter with tRP_cfg-1, then go to WAIT_RP.
- WAIT_RP: cmd_valid=1, strobes 0, counter decrements. At 0, go to REF.
- REF: one cycle.
  - cmd_valid=1, ras=1, cas=1, we=0, a=0.
  - Load the wait counter with tRFC_cfg-1, then go to WAIT_RFC.
- WAIT_RFC: cmd_valid=1, strobes 0, counter decrements. At 0, go to DONE.
- DONE: one cycle. cmd_valid=1, cmd_last=1, pending decrements; go to IDLE.

Rules:
- cmd_ready is sampled only in REQ; it is ignored in all other states.
- cmd_valid stays high continuously from REQ entry through DONE; it never drops while a request is outstanding.
- Strobes and a[10] are 0 in every state other than PRE and REF.
- The wait counter is 10 bits. tRP_cfg is zero-extended into it.
- refresh_en=0 does not abort an in-flight sequence; pending refreshes still drain.

## Timing
Reset values:
- cmd_valid, cmd_first, cmd_last, all strobes, cmd_payload_a, cmd_payload_ba: 0.
- pending: 0; refresh_busy: 0; FSM: IDLE.
- Interval timer: tREFI_cfg-1.

Latencies:
- Tick to cmd_valid=1: 2 cycles (pending update, then REQ entry) when idle.
- Grant (cmd_ready=1 in REQ) to PRE strobe: PRE occurs in the next cycle.
- PRE to REF: exactly tRP_cfg+1 cycles (edge-to-edge).
- REF to DONE: tRFC_cfg+1 cycles.
- DONE to next REQ: 2 cycles (DONE→IDLE→REQ) if pending is still ≠ 0.

Reset mid-sequence:
- rst=1 in any state returns the FSM to IDLE and clears all outputs within the same edge.
- pending returns to 0; no partial sequence resumes.

## Test plan
- Basic refresh:
  - Stimulus: rst, tREFI_cfg=100, tRP_cfg=3, tRFC_cfg=20, refresh_en=1, cmd_ready tied 1.
  - Response: cmd_valid rises at cycle 101; PRE (ras=we=1, a[10]=1, first=1) follows; REF 4 cycles later; cmd_last 21 cycles after REF; pending returns to 0.
- Delayed grant:
  - Stimulus: hold cmd_ready=0 for 50 cycles after REQ.
  - Response: cmd_valid stays 1 with all strobes 0; PRE fires the cycle after cmd_ready=1.
- Postpone saturation:
  - Stimulus: tREFI_cfg=10, cmd_ready=0 for 200 cycles.
  - Response: pending saturates at 8 and extra ticks are dropped; after grant, 8 back-to-back sequences run, each 2 cycles apart from the previous DONE.
- Simultaneous tick and DONE:
  - Stimulus: align a tick with DONE.
  - Response: pending is unchanged that cycle.
- refresh_en low:
  - Stimulus: drop refresh_en mid-sequence.
  - Response: the sequence completes; the timer value is frozen; no new tick until refresh_en is restored.
- Reset in WAIT_RFC:
  - Stimulus: assert rst.
  - Response: next cycle cmd_valid=0, pending=0, FSM in IDLE, timer reloaded.
